// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: timing constants at 50 MHz, the 24-bit GRB pixel
// type and the frame sequencer state encoding.
package ws2812_pkg;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned T0H_CYCLES       = 20;    // 0.40 us high for a '0'
  localparam int unsigned T1H_CYCLES       = 40;    // 0.80 us high for a '1'
  localparam int unsigned BIT_CYCLES       = 63;    // ~1.25 us bit period
  localparam int unsigned LATCH_GAP_CYCLES = 2500;  // >= 50 us line low

  typedef logic [23:0] pixel_t;  // GRB, bit 23 shifted out first

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_DRAIN,
    ST_LATCH
  } seq_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ws2812_frame_sequencer_if.sv
// Pixel stream between the frame sequencer (master) and the bit encoder (slave).
//   pix_valid : pixel available          (master -> slave)
//   pix_data  : pixel, held until taken  (master -> slave)
//   pix_ready : encoder takes the pixel  (slave -> master)
//   enc_idle  : last bit done, line low  (slave -> master)
interface ws2812_frame_sequencer_if;
  import ws2812_pkg::*;

  logic   pix_valid;
  pixel_t pix_data;
  logic   pix_ready;
  logic   enc_idle;

  modport master (output pix_valid, output pix_data, input pix_ready, input enc_idle);
  modport slave  (input pix_valid, input pix_data, output pix_ready, output enc_idle);

endinterface

// File: rtl/ws2812_frame_sequencer_refresh.sv
// Auto-refresh timer: free-running down-counter, reloaded on every frame start,
// pulses tick for one cycle on reaching zero and then reloads itself.
//   clk, rst : clock, synchronous active-high reset (loads the period)
//   reload   : frame starts this cycle
//   tick     : refresh due (constant 0 when REFRESH_CYCLES == 0)
module ws2812_frame_sequencer_refresh
  import ws2812_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tick
);

  localparam int unsigned CNT_W      = cnt_width(REFRESH_CYCLES);
  localparam int unsigned RELOAD_VAL = (REFRESH_CYCLES == 0) ? 0 : REFRESH_CYCLES - 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(RELOAD_VAL);
  localparam bit ENABLED = (REFRESH_CYCLES != 0);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || reload || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tick = ENABLED && (cnt == '0);

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Frame-level WS2812 controller: pixel buffer, frame scheduling (host request or
// auto-refresh), pixel streaming to the bit encoder and the latch gap.
//   clk, rst             : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data: pixel buffer write (addresses >= NUM_LEDS ignored)
//   ovr_en/ovr_color     : whole-frame colour override, latched at frame start
//   frame_req            : request a frame (level or pulse)
//   pix                  : pixel stream to the encoder (master side)
//   busy                 : frame in progress
//   frame_done           : one-cycle pulse at the end of the latch gap
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = 8,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned RESET_CYCLES   = LATCH_GAP_CYCLES,
  parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pixel_t            wr_data,
  input  logic              ovr_en,
  input  pixel_t            ovr_color,
  input  logic              frame_req,
  ws2812_frame_sequencer_if.master pix,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned LCNT_W = cnt_width(RESET_CYCLES);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(RESET_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_LEDS - 1);

  seq_state_t        state, next_state;
  logic [ADDR_W-1:0] idx;
  logic [LCNT_W-1:0] lcnt;
  logic              pending;
  logic              ovr_q;
  pixel_t            ovr_color_q;
  pixel_t            pix_data_q;
  pixel_t            buf_q [NUM_LEDS];
  pixel_t            buf_rd;

  logic refresh_tick;
  logic start_req;
  logic frame_start;
  logic pix_valid_c;
  logic xfer;
  logic last_pix;
  logic lcnt_last;

  ws2812_frame_sequencer_refresh #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh (
    .clk   (clk),
    .rst   (rst),
    .reload(frame_start),
    .tick  (refresh_tick)
  );

  // A request arriving in the very cycle a decision is made counts immediately,
  // so a refresh tick starts an idle frame without a pending-flag round trip.
  assign start_req = pending | frame_req | refresh_tick;
  assign xfer      = pix_valid_c & pix.pix_ready;
  assign last_pix  = (idx == IDX_LAST);
  assign lcnt_last = (lcnt == LCNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (start_req) next_state = ST_FETCH;
      ST_FETCH: next_state = ST_SEND;
      ST_SEND:  if (xfer) next_state = last_pix ? ST_DRAIN : ST_FETCH;
      ST_DRAIN: if (pix.enc_idle) next_state = ST_LATCH;
      ST_LATCH: if (lcnt_last) next_state = start_req ? ST_FETCH : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy        = (state != ST_IDLE);
    pix_valid_c = (state == ST_SEND);
    frame_done  = (state == ST_LATCH) && lcnt_last;
    frame_start = ((state == ST_IDLE) || frame_done) && start_req;
  end

  assign pix.pix_valid = pix_valid_c;
  assign pix.pix_data  = pix_data_q;

  // Compare-based read mux: indices >= NUM_LEDS never select anything.
  always_comb begin
    buf_rd = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (idx == ADDR_W'(i)) buf_rd = buf_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        if (wr_addr == ADDR_W'(i)) buf_q[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= 1'b0;
      idx         <= '0;
      lcnt        <= '0;
      ovr_q       <= 1'b0;
      ovr_color_q <= '0;
      pix_data_q  <= '0;
    end else begin
      if (frame_start) begin
        pending <= 1'b0;
      end else if (frame_req || refresh_tick) begin
        pending <= 1'b1;
      end

      if (frame_start) begin
        ovr_q       <= ovr_en;
        ovr_color_q <= ovr_color;
        idx         <= '0;
      end else if (pix_valid_c && xfer && !last_pix) begin
        idx <= idx + ADDR_W'(1);
      end

      // Registered read: a same-cycle write to this index lands after the fetch.
      if (state == ST_FETCH) begin
        pix_data_q <= ovr_q ? ovr_color_q : buf_rd;
      end

      if ((state == ST_LATCH) && !lcnt_last) begin
        lcnt <= lcnt + LCNT_W'(1);
      end else begin
        lcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
`timescale 1ns/1ps
module tb_ws2812_frame_sequencer;
  import ws2812_pkg::*;

  typedef logic [0:3][23:0] frame_t;
  typedef struct {
    logic       do_wr;
    logic [2:0] addr;
    pixel_t     data;
    logic       ovr;
    pixel_t     color;
    logic       drop_ovr;
    frame_t     exp;
  } vec_t;

  logic       clk;
  logic       rst, rst2;
  logic       wr_en;
  logic [2:0] wr_addr;
  pixel_t     wr_data;
  logic       ovr_en;
  pixel_t     ovr_color;
  logic       frame_req;
  logic       busy, frame_done;
  logic       busy2, done2;

  ws2812_frame_sequencer_if bus ();
  ws2812_frame_sequencer_if bus2 ();

  ws2812_frame_sequencer #(
    .NUM_LEDS(4), .ADDR_W(3), .RESET_CYCLES(20), .REFRESH_CYCLES(0)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ovr_en(ovr_en), .ovr_color(ovr_color), .frame_req(frame_req),
    .pix(bus), .busy(busy), .frame_done(frame_done)
  );

  ws2812_frame_sequencer #(
    .NUM_LEDS(4), .ADDR_W(3), .RESET_CYCLES(20), .REFRESH_CYCLES(500)
  ) dut_refresh (
    .clk(clk), .rst(rst2), .wr_en(1'b0), .wr_addr(3'd0), .wr_data(24'h0),
    .ovr_en(1'b0), .ovr_color(24'h0), .frame_req(1'b0),
    .pix(bus2), .busy(busy2), .frame_done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Encoder model and monitors, all evaluated on the falling edge.
  int     cyc = 0;
  int     wait_n = 0, since = 0;
  pixel_t held;
  bit     stable_bad = 0;
  pixel_t xfer_q[$];
  int     done_cnt = 0, done_cyc = 0, idle_cyc = 0, req_cyc = 0, valid_cyc = 0;
  bit     valid_armed = 0, prev_req = 0, prev_busy = 0, prev_busy2 = 0;
  int     busy_falls = 0, rise2_cnt = 0, last_rise2 = 0, falls2 = 0;

  initial begin
    bus.pix_ready = 1'b0;
    bus.enc_idle  = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (frame_req && !prev_req) begin
        req_cyc     = cyc;
        valid_armed = 1;
      end
      prev_req = frame_req;
      if (bus.pix_valid && valid_armed) begin
        valid_cyc   = cyc;
        valid_armed = 0;
      end
      if (prev_busy && !busy) busy_falls++;
      prev_busy = busy;

      if (busy2 && !prev_busy2) begin
        if (rise2_cnt > 0) check("refresh_period", cyc - last_rise2, 500);
        last_rise2 = cyc;
        rise2_cnt++;
      end
      if (!busy2 && prev_busy2) falls2++;
      prev_busy2 = busy2;

      if (rst) begin
        wait_n = 0;
        since  = 0;
        bus.pix_ready = 1'b0;
        bus.enc_idle  = 1'b1;
      end else if (bus.pix_ready) begin
        bus.pix_ready = 1'b0;
        bus.enc_idle  = 1'b0;
        since = 0;
      end else if (bus.pix_valid) begin
        if (wait_n == 0) held = bus.pix_data;
        else if (bus.pix_data !== held) stable_bad = 1;
        wait_n++;
        if (wait_n == 30) begin
          bus.pix_ready = 1'b1;
          xfer_q.push_back(held);
          wait_n = 0;
        end
      end else if (!bus.enc_idle) begin
        since++;
        if (since == 5) begin
          bus.enc_idle = 1'b1;
          idle_cyc = cyc;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic write_pix(input logic [2:0] a, input pixel_t d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    step(1);
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit, input string name);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      step(1);
      n++;
    end
    check({name, "_done_seen"}, 32'(done_cnt >= target), 1);
  endtask

  task automatic run_frame(input vec_t v, input string name);
    int d0 = done_cnt;
    xfer_q.delete();
    stable_bad = 0;
    ovr_en = v.ovr;
    ovr_color = v.color;
    if (v.do_wr) write_pix(v.addr, v.data);
    pulse_req();
    if (v.drop_ovr) begin
      step(50);
      ovr_en = 1'b0;
      ovr_color = 24'h000001;
    end
    wait_done(d0 + 1, 1000, name);
    check({name, "_latency"}, valid_cyc - req_cyc, 2);
    check({name, "_count"}, xfer_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < xfer_q.size())
        check($sformatf("%s_pix%0d", name, i), xfer_q[i], v.exp[i]);
    end
    check({name, "_stable"}, 32'(stable_bad), 0);
    check({name, "_gap"}, done_cyc - idle_cyc, 20);
    step(5);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_one_done"}, done_cnt, d0 + 1);
    ovr_en = 1'b0;
  endtask

  function automatic vec_t mk(input logic w, input logic [2:0] a, input pixel_t d,
                              input logic o, input pixel_t c, input logic dr, input frame_t e);
    vec_t v;
    v.do_wr = w; v.addr = a; v.data = d; v.ovr = o; v.color = c; v.drop_ovr = dr; v.exp = e;
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    int d0, f0, n;
    vec_t zero_v;
    vecs[0] = mk(0, 3'd0, 24'h0,      0, 24'h0,      0, {24'h00FF00, 24'hFF0000, 24'h0000FF, 24'h123456});
    vecs[1] = mk(1, 3'd5, 24'hABCDEF, 0, 24'h0,      0, {24'h00FF00, 24'hFF0000, 24'h0000FF, 24'h123456});
    vecs[2] = mk(1, 3'd2, 24'h0A0B0C, 0, 24'h0,      0, {24'h00FF00, 24'hFF0000, 24'h0A0B0C, 24'h123456});
    vecs[3] = mk(0, 3'd0, 24'h0,      1, 24'hFFFFFF, 1, {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF});
    vecs[4] = mk(1, 3'd7, 24'h555555, 0, 24'h0,      0, {24'h00FF00, 24'hFF0000, 24'h0A0B0C, 24'h123456});
    vecs[5] = mk(1, 3'd0, 24'h010203, 0, 24'h0,      0, {24'h010203, 24'hFF0000, 24'h0A0B0C, 24'h123456});
    zero_v  = mk(0, 3'd0, 24'h0,      0, 24'h0,      0, {24'h0, 24'h0, 24'h0, 24'h0});

    rst = 1'b1; rst2 = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    ovr_en = 1'b0; ovr_color = '0; frame_req = 1'b0;
    bus2.pix_ready = 1'b1;
    bus2.enc_idle  = 1'b1;
    step(3);
    check("rst_valid", bus.pix_valid, 0);
    check("rst_data", bus.pix_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    rst = 1'b0; rst2 = 1'b0;
    step(2);

    write_pix(3'd0, 24'h00FF00);
    write_pix(3'd1, 24'hFF0000);
    write_pix(3'd2, 24'h0000FF);
    write_pix(3'd3, 24'h123456);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Requests during a frame collapse into one back-to-back frame; a write to a
    // pixel not yet fetched shows up in the frame already running.
    d0 = done_cnt; f0 = busy_falls;
    xfer_q.delete();
    pulse_req();
    write_pix(3'd3, 24'h777777);
    for (int k = 0; k < 3; k++) begin
      step(40);
      pulse_req();
    end
    wait_done(d0 + 2, 2000, "b2b");
    step(100);
    check("b2b_done_cnt", done_cnt, d0 + 2);
    check("b2b_no_gap", busy_falls, f0 + 1);
    check("b2b_xfers", xfer_q.size(), 8);
    if (xfer_q.size() == 8) begin
      check("b2b_pix3", xfer_q[3], 24'h777777);
      check("b2b_pix4", xfer_q[4], 24'h010203);
      check("b2b_pix7", xfer_q[7], 24'h777777);
    end
    check("b2b_idle", busy, 0);

    // Reset while pixel 2 is waiting for the encoder.
    d0 = done_cnt;
    xfer_q.delete();
    pulse_req();
    n = 0;
    while (xfer_q.size() < 2 && n < 500) begin
      step(1);
      n++;
    end
    check("rst_mid_reach_pix2", xfer_q.size(), 2);
    step(10);
    check("rst_mid_valid_before", bus.pix_valid, 1);
    rst = 1'b1;
    step(1);
    check("rst_mid_valid", bus.pix_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data", bus.pix_data, 0);
    rst = 1'b0;
    step(60);
    check("rst_mid_no_done", done_cnt, d0);
    run_frame(zero_v, "after_rst");

    n = 0;
    while (rise2_cnt < 4 && n < 3000) begin
      step(1);
      n++;
    end
    check("refresh_starts", 32'(rise2_cnt >= 4), 1);
    check("refresh_busy_falls", 32'(falls2 >= 3), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
